// File: rtl/eth_rx_ring.sv
// -----------------------------------------------------------------------------
// eth_rx_ring
//
// Multi-slot Ethernet receive frame buffer. It takes the byte stream from the
// GMII/AXIS receiver and stores each frame in its own slot of a ring of SLOTS
// slots. The core reads the oldest committed frame (the "head") through a
// 32-bit word port and frees it with a release pulse. The buffer never
// back-pressures the receiver. A frame that arrives when the ring is full, or
// that exceeds SLOT_BYTES, is dropped and counted.
//
// Optional feature macro: ETH_RX_DROP_BAD_EN
//   When defined, a frame whose tuser is 1 at tlast is discarded and counted in
//   drop_cnt, and head_err is tied to 0.
//   When undefined (the default), such frames are committed with head_err = 1.
//
// Ports
//   clk_rmii       in   1         sole clock, rising edge
//   rst            in   1         asynchronous active-high reset
//   s_axis_tdata   in   8         received byte
//   s_axis_tvalid  in   1         byte valid (tready is implicitly 1)
//   s_axis_tlast   in   1         last byte of frame, qualified by tvalid
//   s_axis_tuser   in   1         bad frame / FCS flag, sampled with tlast
//   irq_en         in   1         interrupt enable
//   rd_addr        in   RA_W      word address within the head slot
//   rd_data        out  32        head-slot word, byte 0 in [7:0], 1-cycle latency
//   frame_release  in   1         pulse: head frame consumed, free its slot
//                                 ("release" is a reserved word in SystemVerilog)
//   head_len       out  LEN_W     byte length of head frame, 0 when empty
//   head_err       out  1         head frame had tuser=1 at tlast
//   frame_cnt      out  SW+1      committed frames waiting
//   drop_cnt       out  16        dropped frames, saturating
//   irq            out  1         registered irq_en & (frame_cnt != 0)
//   dbg_state      out  2         write FSM state (0 IDLE, 1 RECV, 2 DROP)
//
// Stream handshake: the input is a valid-only stream. A byte is accepted on
// every rising edge where s_axis_tvalid is 1. The module has no ready signal
// and never stalls the source. s_axis_tlast and s_axis_tuser only have meaning
// when s_axis_tvalid is 1.
// -----------------------------------------------------------------------------
module eth_rx_ring #(
  parameter int SLOTS      = 4,
  parameter int SLOT_BYTES = 2048,
  localparam int LEN_W     = $clog2(SLOT_BYTES) + 1,
  localparam int SW        = $clog2(SLOTS),
  localparam int RA_W      = $clog2(SLOT_BYTES) - 2
) (
  input  logic              clk_rmii,
  input  logic              rst,
  input  logic [7:0]        s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  input  logic              s_axis_tuser,
  input  logic              irq_en,
  input  logic [RA_W-1:0]   rd_addr,
  output logic [31:0]       rd_data,
  input  logic              frame_release,
  output logic [LEN_W-1:0]  head_len,
  output logic              head_err,
  output logic [SW:0]       frame_cnt,
  output logic [15:0]       drop_cnt,
  output logic              irq,
  output logic [1:0]        dbg_state
);

  localparam int DEPTH = SLOTS * SLOT_BYTES / 4;
  localparam int AW    = SW + RA_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [LEN_W-1:0] offset;      // next byte position in the current slot
  logic [SW-1:0]    wr_slot;
  logic [SW-1:0]    rd_slot;
  logic [LEN_W-1:0] slot_len [SLOTS];

  // Write-side decode
  logic             ring_full;
  logic             wr_en;
  logic [LEN_W-2:0] wr_off;
  logic [AW-1:0]    wr_addr;
  logic [AW-1:0]    rd_word_addr;
  logic             commit;      // frame ended cleanly at tlast
  logic             keep;        // commit that actually takes a slot
  logic             count_drop;
  logic [LEN_W-1:0] commit_len;
  logic             rel_ok;

  assign ring_full    = (frame_cnt == (SW+1)'(SLOTS));
  assign rel_ok       = frame_release && (frame_cnt != '0);
  assign wr_addr      = {wr_slot, wr_off[LEN_W-2:2]};
  assign rd_word_addr = {rd_slot, rd_addr};
  assign dbg_state    = state;

  always_comb begin
    state_nxt  = state;
    wr_en      = 1'b0;
    wr_off     = offset[LEN_W-2:0];
    commit     = 1'b0;
    count_drop = 1'b0;
    commit_len = offset + LEN_W'(1);
    case (state)
      IDLE: begin
        wr_off     = '0;
        commit_len = LEN_W'(1);
        if (s_axis_tvalid) begin
          if (ring_full) begin
            // A one-byte frame that is dropped ends here, so count it now.
            if (s_axis_tlast) count_drop = 1'b1;
            else              state_nxt  = DROP;
          end else begin
            wr_en = 1'b1;
            if (s_axis_tlast) commit    = 1'b1;
            else              state_nxt = RECV;
          end
        end
      end
      RECV: begin
        if (s_axis_tvalid) begin
          if (offset == LEN_W'(SLOT_BYTES)) begin
            // Oversize byte is not written. If it is also the last byte, no
            // later tlast will come for DROP to see, so count it here.
            if (s_axis_tlast) begin
              count_drop = 1'b1;
              state_nxt  = IDLE;
            end else begin
              state_nxt  = DROP;
            end
          end else begin
            wr_en = 1'b1;
            if (s_axis_tlast) begin
              commit    = 1'b1;
              state_nxt = IDLE;
            end
          end
        end
      end
      DROP: begin
        if (s_axis_tvalid && s_axis_tlast) begin
          count_drop = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

`ifdef ETH_RX_DROP_BAD_EN
    keep = commit && !s_axis_tuser;
    if (commit && s_axis_tuser) count_drop = 1'b1;
`else
    keep = commit;
`endif
  end

  // Write FSM, slot bookkeeping and status registers
`ifndef ETH_RX_DROP_BAD_EN
  logic slot_err [SLOTS];
`endif

  always_ff @(posedge clk_rmii or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      offset    <= '0;
      wr_slot   <= '0;
      rd_slot   <= '0;
      frame_cnt <= '0;
      drop_cnt  <= '0;
      irq       <= 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
        slot_len[i] <= '0;
`ifndef ETH_RX_DROP_BAD_EN
        slot_err[i] <= 1'b0;
`endif
      end
    end else begin
      state <= state_nxt;

      if (wr_en) begin
        if (state == IDLE) offset <= LEN_W'(1);
        else               offset <= offset + LEN_W'(1);
      end

      if (keep) begin
        slot_len[wr_slot] <= commit_len;
`ifndef ETH_RX_DROP_BAD_EN
        slot_err[wr_slot] <= s_axis_tuser;
`endif
        wr_slot <= wr_slot + SW'(1);   // SLOTS is a power of 2, so this wraps
      end

      if (rel_ok) rd_slot <= rd_slot + SW'(1);

      // A commit and a release in the same cycle leave the count unchanged.
      case ({keep, rel_ok})
        2'b10:   frame_cnt <= frame_cnt + (SW+1)'(1);
        2'b01:   frame_cnt <= frame_cnt - (SW+1)'(1);
        default: frame_cnt <= frame_cnt;
      endcase

      if (count_drop && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;

      irq <= irq_en && (frame_cnt != '0);
    end
  end

  assign head_len = (frame_cnt != '0) ? slot_len[rd_slot] : '0;
`ifdef ETH_RX_DROP_BAD_EN
  assign head_err = 1'b0;
`else
  assign head_err = (frame_cnt != '0) ? slot_err[rd_slot] : 1'b0;
`endif

  // Storage: one byte lane per byte offset [1:0]. Each lane is written one
  // byte at a time and read as part of a 32-bit word.
  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] ram [DEPTH];
    logic [7:0] q;

    always_ff @(posedge clk_rmii) begin
      if (wr_en && (wr_off[1:0] == 2'(l))) ram[wr_addr] <= s_axis_tdata;
    end

    always_ff @(posedge clk_rmii or posedge rst) begin
      if (rst) q <= '0;
      else     q <= ram[rd_word_addr];
    end
  end

  assign rd_data = {g_lane[3].q, g_lane[2].q, g_lane[1].q, g_lane[0].q};

endmodule

// File: tb/tb_eth_rx_ring.sv
module tb_eth_rx_ring;

  localparam int SLOTS      = 4;
  localparam int SLOT_BYTES = 2048;
  localparam int LEN_W      = $clog2(SLOT_BYTES) + 1;
  localparam int SW         = $clog2(SLOTS);
  localparam int RA_W       = $clog2(SLOT_BYTES) - 2;

  localparam int K_FCNT = 0;
  localparam int K_HLEN = 1;
  localparam int K_HERR = 2;
  localparam int K_DROP = 3;
  localparam int K_IRQ  = 4;
  localparam int K_RDAT = 5;
  localparam int K_RDB0 = 6;

  // ---------------- clock / reset ----------------
  logic clk_rmii = 1'b0;
  logic rst      = 1'b1;
  always #5 clk_rmii = ~clk_rmii;

  logic [7:0]       s_axis_tdata  = '0;
  logic             s_axis_tvalid = 1'b0;
  logic             s_axis_tlast  = 1'b0;
  logic             s_axis_tuser  = 1'b0;
  logic             irq_en        = 1'b0;
  logic [RA_W-1:0]  rd_addr       = '0;
  logic             frame_release = 1'b0;
  logic [31:0]      rd_data;
  logic [LEN_W-1:0] head_len;
  logic             head_err;
  logic [SW:0]      frame_cnt;
  logic [15:0]      drop_cnt;
  logic             irq;
  logic [1:0]       dbg_state;

  eth_rx_ring #(.SLOTS(SLOTS), .SLOT_BYTES(SLOT_BYTES)) dut (
    .clk_rmii      (clk_rmii),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .irq_en        (irq_en),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .frame_release (frame_release),
    .head_len      (head_len),
    .head_err      (head_err),
    .frame_cnt     (frame_cnt),
    .drop_cnt      (drop_cnt),
    .irq           (irq),
    .dbg_state     (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int          kind_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  function automatic string kname(input int k);
    case (k)
      K_FCNT:  return "frame_cnt";
      K_HLEN:  return "head_len";
      K_HERR:  return "head_err";
      K_DROP:  return "drop_cnt";
      K_IRQ:   return "irq";
      K_RDAT:  return "rd_data";
      default: return "rd_data[7:0]";
    endcase
  endfunction

  // The monitor checks every pending expectation at the falling edge, half a
  // cycle after the driver has settled its inputs.
  always @(negedge clk_rmii) begin
    while (exp_q.size() != 0) begin
      logic [31:0] e;
      logic [31:0] a;
      int          k;
      e = exp_q.pop_front();
      k = kind_q.pop_front();
      case (k)
        K_FCNT:  a = 32'(frame_cnt);
        K_HLEN:  a = 32'(head_len);
        K_HERR:  a = 32'(head_err);
        K_DROP:  a = 32'(drop_cnt);
        K_IRQ:   a = 32'(irq);
        K_RDAT:  a = rd_data;
        default: a = 32'(rd_data[7:0]);
      endcase
      n_vec++;
      if (a !== e) begin
        n_err++;
        $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", kname(k), $time, a, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_rmii);
    #1;
  endtask

  task automatic expect_v(input int k, input logic [31:0] v);
    kind_q.push_back(k);
    exp_q.push_back(v);
  endtask

  function automatic logic [31:0] word_of(input logic [7:0] base, input int k);
    logic [7:0] b;
    b = base + 8'(4 * k);
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  task automatic send_frame(input int len, input logic [7:0] base,
                            input logic user, input logic rel_on_last);
    for (int i = 0; i < len; i++) begin
      s_axis_tdata  = base + 8'(i);
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = (i == len - 1);
      s_axis_tuser  = (i == len - 1) ? user : 1'b0;
      frame_release = rel_on_last && (i == len - 1);
      tick();
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
    frame_release = 1'b0;
  endtask

  task automatic do_release();
    frame_release = 1'b1;
    tick();
    frame_release = 1'b0;
  endtask

  task automatic rd_check(input int a, input logic [31:0] e);
    rd_addr = RA_W'(a);
    tick();
    expect_v(K_RDAT, e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] drops;
    do_reset();

    // Reset state
    expect_v(K_FCNT, 0); expect_v(K_HLEN, 0); expect_v(K_HERR, 0);
    expect_v(K_DROP, 0); expect_v(K_IRQ, 0);  expect_v(K_RDAT, 0);
    irq_en = 1'b1;

    // 60-byte frame 0x00..0x3B
    send_frame(60, 8'h00, 1'b0, 1'b0);
    expect_v(K_FCNT, 1); expect_v(K_HLEN, 60); expect_v(K_HERR, 0);
    rd_check(0, 32'h0302_0100);
    expect_v(K_IRQ, 1);
    rd_check(14, 32'h3B3A_3938);
    do_release();
    expect_v(K_FCNT, 0); expect_v(K_HLEN, 0);
    tick();
    expect_v(K_IRQ, 0);

    // Fill the ring from slot 0, overflow by one, then wrap
    do_reset();
    for (int f = 0; f < SLOTS + 1; f++) send_frame(64, 8'(8'h10 * (f + 1)), 1'b0, 1'b0);
    expect_v(K_FCNT, SLOTS); expect_v(K_DROP, 1); expect_v(K_HLEN, 64);
    rd_check(0, word_of(8'h10, 0));
    do_release();
    expect_v(K_FCNT, SLOTS - 1);
    send_frame(64, 8'h60, 1'b0, 1'b0);
    expect_v(K_FCNT, SLOTS); expect_v(K_DROP, 1);
    for (int f = 0; f < SLOTS - 1; f++) begin
      rd_check(0, word_of(8'(8'h20 + 8'h10 * f), 0));
      do_release();
    end
    rd_check(0, 32'h6362_6160);
    rd_check(15, 32'h9F9E_9D9C);
    expect_v(K_HLEN, 64);
    do_release();
    expect_v(K_FCNT, 0);

    // Oversize frame, then a normal frame
    send_frame(SLOT_BYTES + 1, 8'h00, 1'b0, 1'b0);
    expect_v(K_DROP, 2); expect_v(K_FCNT, 0); expect_v(K_HLEN, 0);
    send_frame(64, 8'hA0, 1'b0, 1'b0);
    expect_v(K_FCNT, 1); expect_v(K_HLEN, 64);
    rd_check(0, 32'hA3A2_A1A0);

    // Release on the commit cycle, then release while empty
    send_frame(8, 8'hB0, 1'b0, 1'b1);
    expect_v(K_FCNT, 1); expect_v(K_HLEN, 8);
    rd_check(0, 32'hB3B2_B1B0);
    rd_check(1, 32'hB7B6_B5B4);
    do_release();
    expect_v(K_FCNT, 0);
    do_release();
    expect_v(K_FCNT, 0); expect_v(K_HLEN, 0); expect_v(K_DROP, 2);

    // Single-byte frame and irq_en gating
    send_frame(1, 8'hC5, 1'b0, 1'b0);
    expect_v(K_FCNT, 1); expect_v(K_HLEN, 1);
    rd_addr = '0;
    tick();
    expect_v(K_RDB0, 32'h0000_00C5); expect_v(K_IRQ, 1);
    irq_en = 1'b0;
    tick();
    expect_v(K_IRQ, 0);
    irq_en = 1'b1;
    do_release();
    expect_v(K_FCNT, 0);

    // Bad frame
    send_frame(100, 8'h00, 1'b1, 1'b0);
`ifdef ETH_RX_DROP_BAD_EN
    expect_v(K_FCNT, 0); expect_v(K_DROP, 3); expect_v(K_HERR, 0); expect_v(K_HLEN, 0);
`else
    expect_v(K_FCNT, 1); expect_v(K_HERR, 1); expect_v(K_HLEN, 100); expect_v(K_DROP, 2);
    rd_check(24, 32'h6362_6160);
    do_release();
    expect_v(K_FCNT, 0); expect_v(K_HERR, 0);
`endif

    // Reset in the middle of a frame
    send_frame(20, 8'h55, 1'b0, 1'b0);
    tick();
    expect_v(K_FCNT, 1); expect_v(K_IRQ, 1);
    for (int i = 0; i < 30; i++) begin
      s_axis_tdata  = 8'(8'h80 + i);
      s_axis_tvalid = 1'b1;
      tick();
    end
    s_axis_tvalid = 1'b0;
    rst = 1'b1;
    #1;
    expect_v(K_FCNT, 0); expect_v(K_HLEN, 0); expect_v(K_HERR, 0);
    expect_v(K_DROP, 0); expect_v(K_IRQ, 0);  expect_v(K_RDAT, 0);
    tick();
    rst = 1'b0;
    tick();
    send_frame(50, 8'h70, 1'b0, 1'b0);
    expect_v(K_FCNT, 1); expect_v(K_HLEN, 50); expect_v(K_HERR, 0);
    rd_check(0, 32'h7372_7170);
    rd_check(11, word_of(8'h70, 11));
    drops = 16'd0;
    expect_v(K_DROP, 32'(drops));

    tick();
    tick();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
